// File: rtl/serial_add_ctrl_if.sv
// Handshake/data bundle for serial_add_ctrl: start request with operands in, registered result and status out.
// Latency: none (wires only).
// Backpressure: none; the requester watches oBUSY/oDONE and start requests are dropped while busy.
// Ports: iSTART, iA, iB, iCIN (requester -> adder); oSUM, oCOUT, oOVF, oBUSY, oDONE (adder -> requester).
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             iSTART;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iCIN;
  logic [WIDTH-1:0] oSUM;
  logic             oCOUT;
  logic             oOVF;
  logic             oBUSY;
  logic             oDONE;

  modport master (
    output iSTART, iA, iB, iCIN,
    input  oSUM, oCOUT, oOVF, oBUSY, oDONE
  );

  modport slave (
    input  iSTART, iA, iB, iCIN,
    output oSUM, oCOUT, oOVF, oBUSY, oDONE
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder time-sharing one full-adder cell (two half adders + OR), LSB first.
// Latency: accept edge 0, bits on edges 1..WIDTH, oDONE high the cycle after edge WIDTH; one add per WIDTH+2 cycles.
// Backpressure: iSTART is only sampled in IDLE; requests arriving while busy or done are dropped, not queued.
// Ports: iCLK, iRST_N (async active-low) as plain ports; bus (serial_add_ctrl_if.slave) carries
//        iSTART/iA/iB/iCIN in and oSUM/oCOUT/oOVF/oBUSY/oDONE out.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic             iCLK,
  input logic             iRST_N,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  // Holds the WIDTH-1 sum bits produced so far; the final bit is appended
  // directly when loading oSUM, so no dead LSB flop is needed.
  logic [WIDTH-2:0] resSh;
  logic [WIDTH-1:0] sumReg;
  logic [CW-1:0]    bitCnt;
  logic             carry;
  logic             msbCin;
  logic             coutReg;
  logic             ovfReg;

  logic accept;
  logic lastBit;

  // Full-adder cell built from two half adders and an OR gate.
  logic ha1Sum, ha1Carry, ha2Sum, ha2Carry, cellCarry;
  assign ha1Sum    = aSh[0] ^ bSh[0];
  assign ha1Carry  = aSh[0] & bSh[0];
  assign ha2Sum    = ha1Sum ^ carry;
  assign ha2Carry  = ha1Sum & carry;
  assign cellCarry = ha1Carry | ha2Carry;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastBit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iSTART) begin
          accept    = 1'b1;
          stateNext = ADD;
        end
      end
      ADD: begin
        if (bitCnt == CW'(WIDTH - 1)) begin
          lastBit   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      aSh     <= '0;
      bSh     <= '0;
      resSh   <= '0;
      sumReg  <= '0;
      bitCnt  <= '0;
      carry   <= 1'b0;
      msbCin  <= 1'b0;
      coutReg <= 1'b0;
      ovfReg  <= 1'b0;
    end else if (accept) begin
      aSh    <= bus.iA;
      bSh    <= bus.iB;
      carry  <= bus.iCIN;
      bitCnt <= '0;
    end else if (state == ADD) begin
      aSh   <= aSh >> 1;
      bSh   <= bSh >> 1;
      carry <= cellCarry;
      // New bit enters at the top and walks down; written with shifts so WIDTH=2 still elaborates.
      resSh <= (resSh >> 1) | ((WIDTH-1)'(ha2Sum) << (WIDTH - 2));
      // Carry into the MSB position, kept for the signed-overflow flag.
      if (bitCnt == CW'(WIDTH - 2)) msbCin <= cellCarry;
      if (lastBit) begin
        sumReg  <= {ha2Sum, resSh};
        coutReg <= cellCarry;
        ovfReg  <= msbCin ^ cellCarry;
      end else begin
        bitCnt <= bitCnt + CW'(1);
      end
    end
  end

  assign bus.oSUM  = sumReg;
  assign bus.oCOUT = coutReg;
  assign bus.oOVF  = ovfReg;
  assign bus.oBUSY = (state == ADD);
  assign bus.oDONE = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=32 against an arithmetic A+B+CIN reference.
// Latency: checks oDONE arrives WIDTH edges after the accepting edge and oBUSY spans exactly WIDTH cycles.
// Backpressure: checks start requests during ADD are dropped and a held start restarts every WIDTH+2 cycles.
module tb_serial_add_ctrl;

  logic iCLK = 1'b0;
  logic iRST_N;
  int   checks   = 0;
  int   failures = 0;

  always #5 iCLK = ~iCLK;

  serial_add_ctrl_if #(.WIDTH(8))  b8 ();
  serial_add_ctrl_if #(.WIDTH(32)) b32 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.iCLK(iCLK), .iRST_N(iRST_N), .bus(b8));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.iCLK(iCLK), .iRST_N(iRST_N), .bus(b32));

  // Reference: plain wide addition, signed overflow from operand/result sign bits.
  function automatic void ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] s,
                                  output logic co, output logic ov);
    logic [32:0] full;
    logic [32:0] mask;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, cin};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  // Runs one addition on the selected instance; returns edges from accept to oDONE,
  // number of busy cycles seen, and the outputs sampled in the oDONE cycle.
  task automatic do_add(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output int lat, output int busyCnt,
                        output logic [31:0] sum, output logic cout, output logic ovf);
    logic dn;
    @(negedge iCLK);
    if (wide) begin
      b32.iA = a; b32.iB = b; b32.iCIN = cin; b32.iSTART = 1'b1;
    end else begin
      b8.iA = a[7:0]; b8.iB = b[7:0]; b8.iCIN = cin; b8.iSTART = 1'b1;
    end
    @(negedge iCLK);
    b8.iSTART  = 1'b0;
    b32.iSTART = 1'b0;
    lat = 0;
    busyCnt = 0;
    dn = wide ? b32.oDONE : b8.oDONE;
    while (!dn && lat < 200) begin
      if (wide ? b32.oBUSY : b8.oBUSY) busyCnt++;
      @(negedge iCLK);
      lat++;
      dn = wide ? b32.oDONE : b8.oDONE;
    end
    if (wide) begin
      sum = b32.oSUM; cout = b32.oCOUT; ovf = b32.oOVF;
    end else begin
      sum = {24'd0, b8.oSUM}; cout = b8.oCOUT; ovf = b8.oOVF;
    end
  endtask

  task automatic test_reset();
    iRST_N = 1'b0;
    repeat (3) @(negedge iCLK);
    checks++;
    if ({b8.oSUM, b8.oCOUT, b8.oOVF, b8.oBUSY, b8.oDONE} !== 12'd0) begin
      failures++;
      $display("FAIL reset8 got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
               b8.oSUM, b8.oCOUT, b8.oOVF, b8.oBUSY, b8.oDONE);
    end
    checks++;
    if ({b32.oSUM, b32.oCOUT, b32.oOVF, b32.oBUSY, b32.oDONE} !== 36'd0) begin
      failures++;
      $display("FAIL reset32 got sum=%h busy=%b done=%b want all 0", b32.oSUM, b32.oBUSY, b32.oDONE);
    end
    iRST_N = 1'b1;
    @(negedge iCLK);
    checks++;
    if ({b8.oBUSY, b8.oDONE} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", b8.oBUSY, b8.oDONE);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [3] = '{32'h5A, 32'hFF, 32'h7F};
    logic [31:0] vb [3] = '{32'h3C, 32'h01, 32'h00};
    logic        vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  es [3] = '{8'h96, 8'h00, 8'h80};
    logic        eco[3] = '{1'b0, 1'b1, 1'b0};
    logic        eov[3] = '{1'b1, 1'b0, 1'b1};
    int lat, bc;
    logic [31:0] s;
    logic co, ov;
    for (int i = 0; i < 3; i++) begin
      do_add(1'b0, va[i], vb[i], vc[i], lat, bc, s, co, ov);
      checks++;
      if ({s[7:0], co, ov} !== {es[i], eco[i], eov[i]}) begin
        failures++;
        $display("FAIL directed%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, s[7:0], co, ov, es[i], eco[i], eov[i]);
      end
      checks++;
      if (lat !== 8 || bc !== 8) begin
        failures++;
        $display("FAIL directed_timing%0d got done_edge=%0d busy_cycles=%0d want 8 8", i, lat, bc);
      end
      checks++;
      if (b8.oBUSY !== 1'b0) begin
        failures++;
        $display("FAIL busy_in_done%0d got %b want 0", i, b8.oBUSY);
      end
    end
  endtask

  task automatic test_isolation();
    int doneCnt;
    logic [7:0] s;
    s = 8'hXX;
    @(negedge iCLK);
    b8.iA = 8'h10; b8.iB = 8'h20; b8.iCIN = 1'b0; b8.iSTART = 1'b1;
    @(negedge iCLK);
    b8.iSTART = 1'b0;
    repeat (2) @(negedge iCLK);
    b8.iA = 8'hFF; b8.iSTART = 1'b1;
    @(negedge iCLK);
    b8.iSTART = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (b8.oDONE) begin
        doneCnt++;
        s = b8.oSUM;
      end
      @(negedge iCLK);
    end
    checks++;
    if (s !== 8'h30) begin
      failures++;
      $display("FAIL isolation_sum got %h want 30", s);
    end
    checks++;
    if (doneCnt !== 1) begin
      failures++;
      $display("FAIL isolation_done_count got %0d want 1", doneCnt);
    end
  endtask

  task automatic test_back_to_back();
    int doneCnt;
    @(negedge iCLK);
    b8.iA = 8'h01; b8.iB = 8'h01; b8.iCIN = 1'b0; b8.iSTART = 1'b1;
    doneCnt = 0;
    // i counts sample points after the first accepting edge; ops repeat every 10 cycles:
    // 8 busy cycles, then a DONE cycle, then an IDLE cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge iCLK);
      if (i == 39) b8.iSTART = 1'b0;
      checks++;
      if (b8.oDONE !== ((i % 10) == 8) || b8.oBUSY !== ((i % 10) < 8)) begin
        failures++;
        $display("FAIL b2b_cycle%0d got done=%b busy=%b want done=%b busy=%b",
                 i, b8.oDONE, b8.oBUSY, (i % 10) == 8, (i % 10) < 8);
      end
      if (b8.oDONE) begin
        doneCnt++;
        checks++;
        if (b8.oSUM !== 8'h02) begin
          failures++;
          $display("FAIL b2b_sum got %h want 02", b8.oSUM);
        end
      end
    end
    checks++;
    if (doneCnt !== 4) begin
      failures++;
      $display("FAIL b2b_done_count got %0d want 4", doneCnt);
    end
    repeat (2) @(negedge iCLK);
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic [31:0] s;
    logic co, ov;
    @(negedge iCLK);
    b8.iA = 8'hC3; b8.iB = 8'h5A; b8.iCIN = 1'b1; b8.iSTART = 1'b1;
    @(negedge iCLK);
    b8.iSTART = 1'b0;
    repeat (3) @(negedge iCLK);
    @(posedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    checks++;
    if ({b8.oBUSY, b8.oDONE, b8.oSUM, b8.oCOUT} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b want all 0",
               b8.oBUSY, b8.oDONE, b8.oSUM, b8.oCOUT);
    end
    @(negedge iCLK);
    iRST_N = 1'b1;
    do_add(1'b0, 32'h03, 32'h04, 1'b0, lat, bc, s, co, ov);
    checks++;
    if (s[7:0] !== 8'h07 || co !== 1'b0 || ov !== 1'b0 || lat !== 8 || bc !== 8) begin
      failures++;
      $display("FAIL after_reset got sum=%h cout=%b ovf=%b done_edge=%0d busy=%0d want 07 0 0 8 8",
               s[7:0], co, ov, lat, bc);
    end
  endtask

  task automatic test_random(input bit wide, input int n);
    int w, lat, bc;
    logic [31:0] a, b, s, es;
    logic cin, co, ov, eco, eov;
    w = wide ? 32 : 8;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      b = $urandom;
      // Bias some vectors toward sign-boundary operands.
      if ((i % 8) == 0) a = wide ? 32'h7FFF_FFFF : 32'h7F;
      if ((i % 8) == 1) b = wide ? 32'h8000_0000 : 32'h80;
      if (!wide) begin a &= 32'hFF; b &= 32'hFF; end
      cin = 1'($urandom_range(0, 1));
      ref_add(w, a, b, cin, es, eco, eov);
      do_add(wide, a, b, cin, lat, bc, s, co, ov);
      checks++;
      if (s !== es) begin
        failures++;
        $display("FAIL rand%0d_sum a=%h b=%h cin=%b got %h want %h", w, a, b, cin, s, es);
      end
      checks++;
      if (co !== eco || ov !== eov) begin
        failures++;
        $display("FAIL rand%0d_flags a=%h b=%h cin=%b got cout=%b ovf=%b want cout=%b ovf=%b",
                 w, a, b, cin, co, ov, eco, eov);
      end
      checks++;
      if (lat !== w || bc !== w) begin
        failures++;
        $display("FAIL rand%0d_timing got done_edge=%0d busy=%0d want %0d", w, lat, bc, w);
      end
    end
  endtask

  initial begin
    iRST_N = 1'b0;
    b8.iSTART = 1'b0;  b8.iA = '0;  b8.iB = '0;  b8.iCIN = 1'b0;
    b32.iSTART = 1'b0; b32.iA = '0; b32.iB = '0; b32.iCIN = 1'b0;
    test_reset();
    test_directed();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
